// File: rtl/sd_sector_buffer.sv
// rtl/sd_sector_buffer.sv - 512-byte SD sector buffer with capture/supply streaming and data CRC16
module sd_sector_buffer #(
  parameter int SECTOR_BYTES = 512,
  parameter int ADDR_W       = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              start,
  input  logic [7:0]        sd_incoming_byte,
  input  logic              sd_finished_byte,
  input  logic              sd_finished_sector,
  output logic [7:0]        sd_outgoing_byte,
  output logic              out_valid,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  input  logic              host_we,
  output logic [7:0]        host_rdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   byte_count,
  output logic [15:0]       crc16,
  output logic              err_short,
  output logic              err_overrun
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE, CAPTURE, SUPPLY_FETCH, SUPPLY_WAIT, DONE
  } state_t;

  state_t            r_state, w_next;
  logic [7:0]        r_mem [SECTOR_BYTES];
  logic              r_fin_byte_d, r_fin_sec_d;
  logic [ADDR_W-1:0] r_ptr;
  logic [CNT_W-1:0]  r_byte_count;
  logic [15:0]       r_crc;
  logic [7:0]        r_out_byte, r_host_rdata;
  logic              r_out_valid, r_err_short, r_err_overrun;

  logic              w_byte_ev, w_sec_ev, w_last, w_short, w_busy;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [7:0]        w_wdata, w_crc_in;
  logic [15:0]       w_crc_next;

  // SD data CRC16 (0x1021), one byte per clock, MSB first
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--)
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction

  assign w_byte_ev  = sd_finished_byte & ~r_fin_byte_d;
  assign w_sec_ev   = sd_finished_sector & ~r_fin_sec_d;
  assign w_busy     = (r_state == CAPTURE) || (r_state == SUPPLY_FETCH) || (r_state == SUPPLY_WAIT);
  assign w_last     = w_byte_ev && (r_byte_count == CNT_W'(SECTOR_BYTES - 1));
  assign w_short    = w_sec_ev && !w_last;
  assign w_crc_in   = (r_state == CAPTURE) ? sd_incoming_byte : r_out_byte;
  assign w_crc_next = crc16_byte(r_crc, w_crc_in);

  assign w_we    = ((r_state == IDLE) && host_we) || ((r_state == CAPTURE) && w_byte_ev);
  assign w_waddr = (r_state == IDLE) ? host_addr : r_ptr;
  assign w_wdata = (r_state == IDLE) ? host_wdata : sd_incoming_byte;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:         if (start) w_next = mode ? SUPPLY_FETCH : CAPTURE;
      CAPTURE:      if (w_last || w_short) w_next = DONE;
      SUPPLY_FETCH: begin
        if (w_last || w_short) w_next = DONE;
        else if (!w_byte_ev)   w_next = SUPPLY_WAIT;
      end
      SUPPLY_WAIT: begin
        if (w_last || w_short) w_next = DONE;
        else if (w_byte_ev)    w_next = SUPPLY_FETCH;
      end
      DONE:         w_next = IDLE;
      default:      w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fin_byte_d  <= 1'b0;
      r_fin_sec_d   <= 1'b0;
      r_ptr         <= '0;
      r_byte_count  <= '0;
      r_crc         <= '0;
      r_out_byte    <= '0;
      r_out_valid   <= 1'b0;
      r_host_rdata  <= '0;
      r_err_short   <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_fin_byte_d <= sd_finished_byte;
      r_fin_sec_d  <= sd_finished_sector;
      if (r_state == IDLE) begin
        r_host_rdata <= r_mem[host_addr];
        if (w_byte_ev) r_err_overrun <= 1'b1;
        if (start) begin
          r_ptr         <= '0;
          r_byte_count  <= '0;
          r_crc         <= '0;
          r_err_short   <= 1'b0;
          r_err_overrun <= 1'b0;
        end
      end
      if (w_busy) begin
        if (w_byte_ev) begin
          r_ptr        <= r_ptr + ADDR_W'(1);
          r_byte_count <= r_byte_count + CNT_W'(1);
          r_crc        <= w_crc_next;
          r_out_valid  <= 1'b0;
        end
        // A strobe before the fetched byte is presented consumes the stale byte
        if ((r_state == SUPPLY_FETCH) && w_byte_ev) r_err_overrun <= 1'b1;
        if ((r_state == SUPPLY_FETCH) && !w_byte_ev && !w_short) begin
          r_out_byte  <= r_mem[r_ptr];
          r_out_valid <= 1'b1;
        end
        if (w_short) begin
          r_err_short <= 1'b1;
          r_out_valid <= 1'b0;
        end
      end
      if (r_state == DONE) r_out_valid <= 1'b0;
    end
  end

  assign sd_outgoing_byte = r_out_byte;
  assign out_valid        = r_out_valid;
  assign host_rdata       = r_host_rdata;
  assign busy             = w_busy;
  assign done             = (r_state == DONE);
  assign byte_count       = r_byte_count;
  assign crc16            = r_crc;
  assign err_short        = r_err_short;
  assign err_overrun      = r_err_overrun;

endmodule

// File: tb/tb_sd_sector_buffer.sv
// tb/tb_sd_sector_buffer.sv - self-checking bench for sd_sector_buffer
module tb_sd_sector_buffer;

  localparam int SB = 512;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mode, start;
  logic [7:0]    sd_incoming_byte;
  logic          sd_finished_byte, sd_finished_sector;
  logic [7:0]    sd_outgoing_byte;
  logic          out_valid;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdata;
  logic          host_we;
  logic [7:0]    host_rdata;
  logic          busy, done;
  logic [AW:0]   byte_count;
  logic [15:0]   crc16;
  logic          err_short, err_overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;
  logic [7:0]  ref_mem [SB];
  logic [7:0]  exp_q [$];
  logic [15:0] ref_crc;
  logic [7:0]  b;

  sd_sector_buffer #(.SECTOR_BYTES(SB), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .start(start),
    .sd_incoming_byte(sd_incoming_byte), .sd_finished_byte(sd_finished_byte),
    .sd_finished_sector(sd_finished_sector), .sd_outgoing_byte(sd_outgoing_byte),
    .out_valid(out_valid), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_we(host_we), .host_rdata(host_rdata), .busy(busy), .done(done),
    .byte_count(byte_count), .crc16(crc16), .err_short(err_short), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_seen++;

  function automatic logic [15:0] crc_ser(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = r << 1;
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic m);
    mode = m; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] d);
    sd_incoming_byte = d; sd_finished_byte = 1'b1;
    tick();
    sd_finished_byte = 1'b0;
    tick();
  endtask

  task automatic sector_end();
    sd_finished_sector = 1'b1;
    tick();
    sd_finished_sector = 1'b0;
    tick();
  endtask

  task automatic host_read(input int a, input string tag);
    host_addr = AW'(a);
    tick();
    chk(tag, {24'h0, host_rdata}, {24'h0, ref_mem[a]});
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; mode = 1'b0; start = 1'b0; sd_incoming_byte = '0;
    sd_finished_byte = 1'b0; sd_finished_sector = 1'b0;
    host_addr = '0; host_wdata = '0; host_we = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_errs", {err_short, err_overrun}, 0);
    chk("rst_outbyte", sd_outgoing_byte, 0);
    chk("rst_rdata", host_rdata, 0);
    chk("rst_crc", crc16, 0);
    chk("rst_count", byte_count, 0);
    rst_n = 1'b1;
    tick();

    // capture 100 bytes, then reset mid-transfer
    do_start(1'b0);
    chk("cap_busy", busy, 1);
    for (int i = 0; i < 100; i++) begin
      b = 8'(i * 7 + 3);
      ref_mem[i] = b;
      strobe(b);
    end
    chk("cap100_count", byte_count, 100);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_count", byte_count, 0);
    chk("midrst_crc", crc16, 0);
    host_read(5, "midrst_rd5");

    // host fill, then supply the sector
    host_we = 1'b1;
    for (int i = 0; i < SB; i++) begin
      host_addr = AW'(i); host_wdata = 8'(i); ref_mem[i] = 8'(i);
      tick();
    end
    host_we = 1'b0;
    host_read(300, "fill_rd300");
    ref_crc = '0;
    for (int i = 0; i < SB; i++) exp_q.push_back(ref_mem[i]);
    d0 = done_seen;
    do_start(1'b1);
    for (int i = 0; i < SB; i++) begin
      int w;
      w = 0;
      while (!out_valid && w < 8) begin tick(); w++; end
      if (!out_valid) chk("sup_valid_timeout", 0, 1);
      b = exp_q.pop_front();
      chk("sup_byte", sd_outgoing_byte, b);
      ref_crc = crc_ser(ref_crc, b);
      strobe(8'h00);
    end
    tick();
    chk("sup_done", done_seen - d0, 1);
    chk("sup_count", byte_count, SB);
    chk("sup_crc", crc16, ref_crc);
    chk("sup_errs", {err_short, err_overrun}, 0);
    chk("sup_busy", busy, 0);

    // capture 512 x 0xFF
    ref_crc = '0;
    d0 = done_seen;
    do_start(1'b0);
    for (int i = 0; i < SB; i++) begin
      ref_mem[i] = 8'hFF;
      ref_crc = crc_ser(ref_crc, 8'hFF);
      strobe(8'hFF);
    end
    tick();
    chk("ff_done", done_seen - d0, 1);
    chk("ff_crc_const", crc16, 16'h7FA1);
    chk("ff_crc_model", crc16, ref_crc);
    chk("ff_count", byte_count, SB);
    chk("ff_errs", {err_short, err_overrun}, 0);
    host_read(0, "ff_rd0");
    host_read(255, "ff_rd255");
    host_read(511, "ff_rd511");

    // short sector
    ref_crc = '0;
    d0 = done_seen;
    do_start(1'b0);
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom_range(0, 255));
      ref_mem[i] = b;
      ref_crc = crc_ser(ref_crc, b);
      strobe(b);
    end
    sector_end();
    chk("short_err", err_short, 1);
    chk("short_done", done_seen - d0, 1);
    chk("short_count", byte_count, 10);
    chk("short_crc", crc16, ref_crc);
    chk("short_busy", busy, 0);
    host_read(9, "short_rd9");

    // strobe while idle, then held strobe in capture
    strobe(8'h5A);
    chk("idle_overrun", err_overrun, 1);
    do_start(1'b0);
    chk("start_clr_overrun", err_overrun, 0);
    chk("start_clr_short", err_short, 0);
    sd_incoming_byte = 8'hC3; sd_finished_byte = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    sd_finished_byte = 1'b0;
    tick();
    chk("held_count", byte_count, 1);
    chk("held_crc", crc16, crc_ser(16'h0, 8'hC3));
    sector_end();
    chk("held_short", err_short, 1);

    // supply strobe before the first byte is presented
    do_start(1'b1);
    chk("ovr_valid0", out_valid, 0);
    strobe(8'h00);
    chk("sup_overrun", err_overrun, 1);
    chk("sup_ovr_count", byte_count, 1);
    sector_end();
    chk("sup_ovr_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
